// File: rtl/delay_line_probe_pkg.sv
// Shared definitions for the delay-line latency probe: FSM state encoding,
// default marker pattern and default counter width.
package delay_line_probe_pkg;

  localparam int         DEF_CNT_W   = 8;
  localparam logic [7:0] DEF_PATTERN = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } probe_state_e;

endpackage

// File: rtl/delay_line_probe_if.sv
// Request/result bundle between the probe and its environment. The master side
// issues start and returns the delay line output; the slave side is the probe.
interface delay_line_probe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [DATA_W-1:0] probe_data;
  logic [DATA_W-1:0] line_out;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  latency;
  logic              corrupt;

  modport master (
    output start, line_out,
    input  probe_data, busy, done, timeout, latency, corrupt
  );

  modport slave (
    input  start, line_out,
    output probe_data, busy, done, timeout, latency, corrupt
  );
endinterface

// File: rtl/delay_line_probe_counter.sv
// Saturating up-counter shared by the flush and wait phases. Synchronous clear
// wins over enable; tc flags the all-ones value where counting stops.
module delay_probe_counter
  import delay_line_probe_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  localparam logic [CNT_W-1:0] MAX = '1;

  assign tc = (count == MAX);

  // Count up while enabled, hold at MAX, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count <= '0;
    else if (clr)        count <= '0;
    else if (en && !tc)  count <= count + 1'b1;
  end
endmodule

// File: rtl/delay_line_probe.sv
// Latency probe for fixed-latency delay lines: flushes the line with zeros,
// injects a one-cycle marker and counts cycles until the marker reappears.
// Optional build macro DELAY_PROBE_CORRUPT_CHECK_EN enables a sticky flag for
// unexpected non-zero line values seen while waiting for the marker.
module delay_line_probe
  import delay_line_probe_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                CNT_W        = DEF_CNT_W,
  parameter logic [DATA_W-1:0] PATTERN      = DATA_W'(DEF_PATTERN),
  parameter int                FLUSH_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  delay_line_probe_if.slave   bus
);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

  probe_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tc, cnt_clr, cnt_en;
  logic             match, hit, expire;

  assign match = (bus.line_out == PATTERN);

  delay_probe_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .tc    (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and counter control. LAUNCH already checks for a match with
  // count 0 so a zero-latency path is measurable. Saturation wins over a
  // match at the all-ones count, keeping the largest reportable value at 2^CNT_W-2.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    hit       = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (bus.start) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_LAUNCH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LAUNCH, ST_WAIT: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          expire    = 1'b1;
          state_nxt = ST_DONE;
        end else if (match) begin
          hit       = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, computed from the next state so the marker is on
  // probe_data exactly during the LAUNCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.probe_data <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.latency    <= '0;
    end else begin
      bus.probe_data <= (state_nxt == ST_LAUNCH) ? PATTERN : '0;
      bus.busy       <= (state_nxt != ST_IDLE);
      bus.done       <= hit;
      bus.timeout    <= expire;
      if (hit) bus.latency <= cnt;
    end
  end

`ifdef DELAY_PROBE_CORRUPT_CHECK_EN
  logic corrupt_q;

  // Sticky flag for garbage on the line before the marker; a new accepted
  // start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              corrupt_q <= 1'b0;
    else if (state == ST_IDLE && bus.start)  corrupt_q <= 1'b0;
    else if (state == ST_WAIT && !match && (bus.line_out != '0))
                                             corrupt_q <= 1'b1;
  end

  assign bus.corrupt = corrupt_q;
`else
  assign bus.corrupt = 1'b0;
`endif

endmodule

// File: tb/tb_delay_line_probe.sv
// Directed bench for delay_line_probe: a 60-register chain model, a direct
// wire and a stuck-at-zero line, plus held-start, mid-run reset and an
// injected corruption value (flag expected only with DELAY_PROBE_CORRUPT_CHECK_EN).
module tb_delay_line_probe;
  localparam int         DW    = 8;
  localparam int         CW    = 8;
  localparam logic [7:0] PAT   = 8'hA5;
  localparam int         DEPTH = 60;
  localparam int         FLUSH = 255;
`ifdef DELAY_PROBE_CORRUPT_CHECK_EN
  localparam bit CORR_EN = 1'b1;
`else
  localparam bit CORR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  delay_line_probe_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  delay_line_probe #(
    .DATA_W(DW), .CNT_W(CW), .PATTERN(PAT), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef enum int {M_WIRE, M_CHAIN, M_ZERO} mode_e;

  mode_e      mode;
  logic       inj_en;
  logic [7:0] chain [DEPTH];

  // Delay line model: DEPTH registers fed by probe_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
    end else begin
      chain[0] <= bus.probe_data;
      for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
    end
  end

  // Line selection, with a one-cycle 0x3C override for the corruption case.
  always_comb begin
    case (mode)
      M_WIRE:  bus.line_out = bus.probe_data;
      M_ZERO:  bus.line_out = '0;
      default: bus.line_out = chain[DEPTH-1];
    endcase
    if (inj_en) bus.line_out = 8'h3C;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int n_done, n_to, n_pat, pat_idx, end_idx;

  // One measurement: pulse (or hold) start, then watch every cycle until busy drops.
  task automatic do_run(input bit hold, input int inj_at, input string tag);
    int idx;
    n_done = 0; n_to = 0; n_pat = 0; pat_idx = -1; end_idx = -1;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); if (!hold) bus.start = 1'b0;
    chk({tag, ".busy_on"}, bus.busy, 1);
    chk({tag, ".corrupt_clr"}, bus.corrupt, 0);
    idx = 0;
    while (bus.busy && idx < 1200) begin
      if (bus.probe_data == PAT) begin
        n_pat++;
        if (pat_idx < 0) pat_idx = idx;
      end
      if (bus.done)    begin n_done++; end_idx = idx; end
      if (bus.timeout) begin n_to++;   end_idx = idx; end
      inj_en = (inj_at >= 0 && pat_idx >= 0 && idx == pat_idx + inj_at);
      @(negedge clk);
      idx++;
    end
    inj_en = 1'b0;
    chk({tag, ".bounded"}, bus.busy, 0);
  endtask

  typedef struct {
    mode_e mode;
    int    inj_at;
    int    exp_done;
    int    exp_to;
    int    exp_lat;
    int    exp_delta;
    bit    exp_corr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    bus.start = 1'b0;
    mode      = M_CHAIN;
    inj_en    = 1'b0;

    // mode, inject offset, done, timeout, latency, pattern-to-result cycles, corrupt
    vecs[0] = '{M_WIRE,  -1, 1, 0,  0,   1, 1'b0};
    vecs[1] = '{M_CHAIN, -1, 1, 0, 60,  61, 1'b0};
    vecs[2] = '{M_ZERO,  -1, 0, 1, 60, 256, 1'b0};
    vecs[3] = '{M_CHAIN, 10, 1, 0, 60,  61, CORR_EN};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst.probe_data", bus.probe_data, 0);
    chk("rst.busy",       bus.busy, 0);
    chk("rst.done",       bus.done, 0);
    chk("rst.timeout",    bus.timeout, 0);
    chk("rst.latency",    bus.latency, 0);
    chk("rst.corrupt",    bus.corrupt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      do_run(1'b0, vecs[i].inj_at, $sformatf("v%0d", i));
      chk($sformatf("v%0d.pat_count", i), n_pat, 1);
      chk($sformatf("v%0d.pat_idx", i),   pat_idx, FLUSH);
      chk($sformatf("v%0d.done", i),      n_done, vecs[i].exp_done);
      chk($sformatf("v%0d.timeout", i),   n_to, vecs[i].exp_to);
      chk($sformatf("v%0d.delta", i),     end_idx - pat_idx, vecs[i].exp_delta);
      chk($sformatf("v%0d.latency", i),   bus.latency, vecs[i].exp_lat);
      chk($sformatf("v%0d.corrupt", i),   bus.corrupt, vecs[i].exp_corr);
    end

    // Start held through a whole run and DONE: one result, then a restart
    // only after IDLE has been visited.
    mode = M_CHAIN;
    do_run(1'b1, -1, "hold");
    chk("hold.done",    n_done, 1);
    chk("hold.latency", bus.latency, 60);
    chk("hold.idle_gap", bus.busy, 0);
    @(negedge clk);
    chk("hold.restart", bus.busy, 1);
    bus.start = 1'b0;
    for (int c = 0; c < 1200 && bus.busy; c++) @(negedge clk);
    chk("hold.second_end", bus.busy, 0);
    chk("hold.second_lat", bus.latency, 60);

    // Reset in the middle of WAIT aborts everything, then a clean rerun.
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < 400 && bus.probe_data !== PAT; c++) @(negedge clk);
    chk("mid.launch_seen", bus.probe_data, PAT);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.busy",       bus.busy, 0);
    chk("mid.done",       bus.done, 0);
    chk("mid.timeout",    bus.timeout, 0);
    chk("mid.latency",    bus.latency, 0);
    chk("mid.probe_data", bus.probe_data, 0);
    chk("mid.corrupt",    bus.corrupt, 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    do_run(1'b0, -1, "post_rst");
    chk("post_rst.done",    n_done, 1);
    chk("post_rst.latency", bus.latency, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
